uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  UART receiver, 8N1, LSB first: receive path paired with the UART transmitter.
//  Oversamples the serial line with the system clock and samples each bit at its centre.
//  Presents each good byte on a parallel bus with a one-cycle valid strobe.
//  Flags stop-bit framing errors.
//  Sits between the board Rx pin (or Tx in loopback) and the byte consumer.
// PARAMETERS
//  CLK_FREQ      50000000               system clock frequency, Hz
//  BAUD_RATE     9600                   line rate, bit/s
//  CLKS_PER_BIT  CLK_FREQ/BAUD_RATE     clocks per bit (5208); benches override to 16
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst_n      in   1  synchronous, active-low reset
//  Rx         in   1  asynchronous serial input; idle high
//  rx_data    out  8  last good byte; held until the next good byte
//  rx_valid   out  1  one-cycle pulse: rx_data updated this cycle
//  frame_err  out  1  one-cycle pulse: stop bit sampled low; byte discarded
//  busy       out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - state=IDLE; rx_data=8'h00; rx_valid=frame_err=busy=0
//   - counters=0; both sync flops=1; armed=0
//   - Reset mid-frame abandons the frame silently: no valid, no error pulse.
//  Synchroniser
//   - Rx passes through 2 flops -> rx_s; all decisions use rx_s.
//   - armed sets when rx_s==1 is seen in IDLE.
//   - Start detection requires armed=1, so a line held low through reset is ignored until it goes high.
//  Baud counter: clk_cnt, width $clog2(CLKS_PER_BIT); cleared on every state change.
//  FSM
//   - IDLE: armed && rx_s==0 -> START.
//   - START: at clk_cnt==(CLKS_PER_BIT-1)/2 (mid start bit), sample rx_s.
//     - 0 -> DATA, bit_idx=0.
//     - 1 -> glitch: IDLE. No output pulse; armed stays set.
//   - DATA: at clk_cnt==CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first).
//     - bit_idx 0..7; after bit 7 -> STOP.
//   - STOP: at clk_cnt==CLKS_PER_BIT-1, sample rx_s.
//     - 1 -> rx_data<=shift, rx_valid=1 for the next cycle, then IDLE.
//     - 0 -> frame_err=1 for the next cycle; rx_data unchanged; -> WAIT_IDLE.
//   - WAIT_IDLE: stay until rx_s==1 (break/long low), then IDLE.
//  Timing
//   - Next start bit is accepted from the cycle after returning to IDLE.
//   - Because the stop sample is mid-bit, back-to-back frames with one stop bit are never lost.
//   - Latency, Rx falling edge -> rx_valid: 2 (sync) + ~9.5*CLKS_PER_BIT + 1 clocks.
//  Pulse rules
//   - rx_valid and frame_err are mutually exclusive and never high for two consecutive cycles.
//   - No overrun detection: the consumer must take rx_data before the next rx_valid.
//  Sampling: single centre sample per bit, no majority vote; tolerates up to +/-(CLKS_PER_BIT/2-2) clocks of drift per frame.
// TESTING (CLKS_PER_BIT=16, CLK_FREQ=50e6)
//  1. Drive 0xA5 (start, 1,0,1,0,0,1,0,1, stop)
//     -> one rx_valid pulse; rx_data=8'hA5; frame_err never high.
//  2. Back-to-back 0x00 then 0xFF, one stop bit each
//     -> two rx_valid pulses, rx_data 8'h00 then 8'hFF, ~160 clk apart.
//  3. Low glitch of 4 clk on idle line
//     -> no rx_valid, no frame_err; busy returns 0 within 12 clk; a following 0x3C is received correctly.
//  4. 0x3C with stop bit forced 0, line held low 5 bit times, then 0x5A
//     -> frame_err pulse once; rx_data unchanged; then rx_valid with 8'h5A.
//  5. rst_n low for 2 clk during data bit 3; Rx held low across release
//     -> no pulses; idle until Rx high; the next 0x81 frame is received.
//  6. Loopback: transmitter output into Rx, transmitter sends 0xA5
//     -> rx_valid with rx_data=8'hA5.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver, LSB first. Two-flop synchroniser,
// single centre sample per bit, one-cycle valid / framing-error strobes.
module uart_rx_core #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic [1:0]    r_fill;
    logic          r_armed;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_frame_err;
    logic          r_busy;
    logic          w_rx_s;
    logic          w_mid_hit;
    logic          w_last_hit;

    assign w_rx_s     = r_sync2;
    assign w_mid_hit  = (r_clk_cnt == MID_CNT);
    assign w_last_hit = (r_clk_cnt == LAST_CNT);

    // Synchroniser; r_fill marks when rx_s reflects the line rather than the reset value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_fill  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= Rx;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            if ((r_state == S_IDLE) && r_fill[1] && w_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !w_rx_s) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_mid_hit) begin
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_last_hit && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = S_STOP;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_STOP: begin
                if (w_last_hit) begin
                    w_state_nxt = w_rx_s ? S_IDLE : S_WAIT_IDLE;
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            S_WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Baud counter: restarts on every state change, wraps once per bit in DATA.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_clk_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_clk_cnt <= '0;
        end else if ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP)) begin
            if (w_last_hit) begin
                r_clk_cnt <= '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            r_clk_cnt <= '0;
        end
    end

    // Data bit capture, LSB first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else if ((r_state == S_START) && w_mid_hit) begin
            r_bit_idx <= 3'd0;
        end else if ((r_state == S_DATA) && w_last_hit) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_bit_idx          <= r_bit_idx + 3'd1;
        end
    end

    // Registered outputs; the stop-bit sample decides between valid and framing error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= (w_state_nxt != S_IDLE);
            if ((r_state == S_STOP) && w_last_hit) begin
                if (w_rx_s) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized bench for uart_rx_core (CLKS_PER_BIT=16); expected
// events come from a frame-level model (good stop -> byte, bad stop -> error).
module tb_uart_rx_core;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pin_rx;
    logic       tx_pin;
    logic       loopback;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rx_line = loopback ? tx_pin : pin_rx;

    uart_rx_core #(
        .CLK_FREQ    (50000000),
        .BAUD_RATE   (3125000),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Rx       (rx_line),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Observed pulse events.
    int          ev_kind[$];
    logic [7:0]  ev_data[$];
    int unsigned ev_cyc[$];
    int          pulse_viol = 0;
    logic        prev_pulse = 1'b0;

    // Expected events from the frame-level model.
    int          exp_kind[$];
    logic [7:0]  exp_data[$];
    logic [7:0]  last_good = 8'h00;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            ev_kind.push_back(0);
            ev_data.push_back(rx_data);
            ev_cyc.push_back(cyc);
        end
        if (frame_err === 1'b1) begin
            ev_kind.push_back(1);
            ev_data.push_back(rx_data);
            ev_cyc.push_back(cyc);
        end
        if (((rx_valid === 1'b1) && (frame_err === 1'b1)) ||
            (((rx_valid === 1'b1) || (frame_err === 1'b1)) && prev_pulse)) begin
            pulse_viol++;
        end
        prev_pulse = (rx_valid === 1'b1) || (frame_err === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_kind.push_back(0);
            exp_data.push_back(b);
            last_good = b;
        end else begin
            exp_kind.push_back(1);
            exp_data.push_back(last_good);
        end
    endtask

    task automatic drive_bit(input logic b);
        pin_rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        model_frame(b, stop_bit);
    endtask

    // Simple transmitter model for the loopback path: 10-bit word shifted out LSB first.
    task automatic tx_send(input logic [7:0] b);
        logic [9:0] word;
        word = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tx_pin = word[0];
            word   = word >> 1;
            tick(CPB);
        end
        model_frame(b, 1'b1);
    endtask

    task automatic compare_events(input string tag);
        int n;
        chk({tag, " count"}, ev_kind.size(), exp_kind.size());
        n = (ev_kind.size() < exp_kind.size()) ? ev_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s kind%0d", tag, i), ev_kind[i], exp_kind[i]);
            chk($sformatf("%s data%0d", tag, i), {24'h0, ev_data[i]}, {24'h0, exp_data[i]});
        end
        ev_kind.delete();
        ev_data.delete();
        ev_cyc.delete();
        exp_kind.delete();
        exp_data.delete();
    endtask

    initial begin
        int unsigned c0;
        int unsigned meas;
        int          k;
        int          busy_hits;
        logic [7:0]  b;
        logic        good;
        int          gap;

        rst_n    = 1'b0;
        pin_rx   = 1'b1;
        tx_pin   = 1'b1;
        loopback = 1'b0;
        @(negedge clk);
        tick(3);
        chk("reset rx_data", {24'h0, rx_data}, 32'h0);
        chk("reset rx_valid", {31'h0, rx_valid}, 32'h0);
        chk("reset frame_err", {31'h0, frame_err}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        tick(5);

        // 1: single 0xA5 with latency check
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        tick(20);
        meas = (ev_cyc.size() > 0) ? (ev_cyc[0] - c0) : 0;
        chk("t1 latency", meas, 32'd155);
        compare_events("t1");

        // 2: back-to-back 0x00, 0xFF
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(20);
        meas = (ev_cyc.size() > 1) ? (ev_cyc[1] - ev_cyc[0]) : 0;
        chk("t2 spacing", meas, 32'd160);
        compare_events("t2");

        // 3: 4-clock low glitch, then 0x3C
        pin_rx = 1'b0;
        tick(4);
        pin_rx = 1'b1;
        k = 4;
        while ((k < 12) && (busy !== 1'b0)) begin
            tick(1);
            k++;
        end
        chk("t3 busy clear", {31'h0, busy}, 32'h0);
        tick(16);
        compare_events("t3 glitch");
        send_frame(8'h3C, 1'b1);
        tick(20);
        compare_events("t3");

        // 4: framing error, long low, then 0x5A
        send_frame(8'h3C, 1'b0);
        pin_rx = 1'b0;
        tick(5 * CPB);
        pin_rx = 1'b1;
        tick(CPB);
        send_frame(8'h5A, 1'b1);
        tick(20);
        compare_events("t4");
        chk("t4 rx_data", {24'h0, rx_data}, 32'h5A);

        // 5: reset during data bit 3 with line held low across release
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        tick(CPB / 2);
        rst_n  = 1'b0;
        pin_rx = 1'b0;
        tick(2);
        rst_n     = 1'b1;
        last_good = 8'h00;
        busy_hits = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            tick(1);
            if (busy !== 1'b0) busy_hits++;
        end
        chk("t5 busy while low", busy_hits, 32'd0);
        chk("t5 rx_data cleared", {24'h0, rx_data}, 32'h0);
        compare_events("t5 quiet");
        pin_rx = 1'b1;
        tick(CPB);
        send_frame(8'h81, 1'b1);
        tick(20);
        compare_events("t5");

        // 6: loopback through transmitter model
        loopback = 1'b1;
        tx_send(8'hA5);
        tick(20);
        loopback = 1'b0;
        compare_events("t6");

        // 7: randomized frames, occasional bad stop bit, random idle gaps
        for (int f = 0; f < 12; f++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 4) != 0);
            send_frame(b, good);
            pin_rx = 1'b1;
            gap = good ? $urandom_range(0, 8) : $urandom_range(4, 12);
            tick(gap);
        end
        tick(20);
        compare_events("t7 random");

        chk("pulse rules", pulse_viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
